// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage with internal word RAM, multi-cycle loads and hazard stall
module mem_access_stage #(
    parameter int ADDR_W   = 8,
    parameter int LOAD_LAT = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [2:0]  Op_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] store_data_i,
    input  logic [4:0]  rsd_i,
    output logic        stall_o,
    output logic        valid_o,
    output logic [31:0] wb_data_o,
    output logic [4:0]  rsd_o,
    output logic        reg_write_o,
    output logic        err_o
);
    localparam logic [2:0] OP_ALU   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_STORE = 3'b010;
    localparam int CW = (LOAD_LAT > 2) ? $clog2(LOAD_LAT - 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LOAD_LAT > 1 ? LOAD_LAT - 2 : 0);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [31:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] idx;
    logic              misal, stall_c, mem_we;
    logic              v_n, we_n, err_n;
    logic [31:0]       d_n;

    assign idx     = alu_result_i[ADDR_W+1:2];
    assign misal   = alu_result_i[1:0] != 2'b00;
    assign stall_o = rst_i & stall_c;

    // Next-state and next MEM/WB values; a load samples the RAM only on its completion cycle
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        stall_c = 1'b0;
        mem_we  = 1'b0;
        v_n     = valid_i;
        d_n     = 32'd0;
        we_n    = 1'b0;
        err_n   = 1'b0;
        if (state == WAIT) begin
            if (!valid_i) begin
                state_n = IDLE;
                v_n     = 1'b0;
            end else if (cnt != '0) begin
                stall_c = 1'b1;
                cnt_n   = cnt - 1'b1;
                v_n     = 1'b0;
            end else begin
                state_n = IDLE;
                d_n     = mem[idx];
                we_n    = rsd_i != 5'd0;
            end
        end else if (valid_i) begin
            if (Op_i == OP_ALU) begin
                d_n  = alu_result_i;
                we_n = rsd_i != 5'd0;
            end else if (Op_i == OP_LOAD) begin
                if (misal) begin
                    err_n = 1'b1;
                end else if (LOAD_LAT > 1) begin
                    stall_c = 1'b1;
                    state_n = WAIT;
                    cnt_n   = CNT_INIT;
                    v_n     = 1'b0;
                end else begin
                    d_n  = mem[idx];
                    we_n = rsd_i != 5'd0;
                end
            end else if (Op_i == OP_STORE) begin
                err_n  = misal;
                mem_we = !misal;
            end
        end
    end

    // FSM and MEM/WB pipeline register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            valid_o     <= 1'b0;
            wb_data_o   <= 32'd0;
            rsd_o       <= 5'd0;
            reg_write_o <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            valid_o     <= v_n;
            wb_data_o   <= d_n;
            rsd_o       <= rsd_i;
            reg_write_o <= we_n;
            err_o       <= err_n;
        end
    end

    // Data RAM write port; contents survive reset
    always_ff @(posedge clk_i) begin
        if (rst_i && mem_we) mem[idx] <= store_data_i;
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed table, corner sequences and random run against a word-RAM model
module tb_mem_access_stage;
    localparam int L     = 3;
    localparam int S     = L - 1;
    localparam int DEPTH = 256;

    typedef struct {
        bit          v;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] d;
        logic [4:0]  r;
        int          stalls;
        bit          e_valid;
        logic [31:0] e_data;
        bit          e_we;
        bit          e_err;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        valid_i = 1'b0;
    logic [2:0]  Op_i = 3'd0;
    logic [31:0] alu_result_i = 32'd0;
    logic [31:0] store_data_i = 32'd0;
    logic [4:0]  rsd_i = 5'd0;
    logic        stall_o, valid_o, reg_write_o, err_o;
    logic [31:0] wb_data_o;
    logic [4:0]  rsd_o;

    int          passed = 0;
    int          total = 0;
    logic [31:0] ram_m [DEPTH];
    vec_t        tbl [16];

    mem_access_stage #(.ADDR_W(8), .LOAD_LAT(L)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .Op_i(Op_i),
        .alu_result_i(alu_result_i), .store_data_i(store_data_i), .rsd_i(rsd_i),
        .stall_o(stall_o), .valid_o(valid_o), .wb_data_o(wb_data_o), .rsd_o(rsd_o),
        .reg_write_o(reg_write_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", n, act, exp);
    endtask

    function automatic vec_t model(bit v, logic [2:0] op, logic [31:0] a, logic [31:0] d, logic [4:0] r);
        vec_t m;
        int unsigned w = (a / 4) % DEPTH;
        bit mis = (a % 4) != 0;
        bit ld = v && op == 3'd1;
        m.v = v; m.op = op; m.a = a; m.d = d; m.r = r;
        m.stalls  = (ld && !mis) ? L - 1 : 0;
        m.e_valid = v;
        m.e_err   = v && (op == 3'd1 || op == 3'd2) && mis;
        m.e_we    = v && r != 0 && (op == 3'd0 || (ld && !mis));
        m.e_data  = !v ? 32'd0 : op == 3'd0 ? a : (ld && !mis) ? ram_m[w] : 32'd0;
        return m;
    endfunction

    task automatic apply(input vec_t t, input string n);
        valid_i = t.v; Op_i = t.op; alu_result_i = t.a; store_data_i = t.d; rsd_i = t.r;
        for (int k = 0; k < t.stalls; k++) begin
            #1 chk({n, " stall"}, 32'(stall_o), 32'd1);
            @(posedge clk_i); #1;
            chk({n, " bubble valid"}, 32'(valid_o), 32'd0);
            chk({n, " bubble we"}, 32'(reg_write_o), 32'd0);
        end
        #1 chk({n, " stall end"}, 32'(stall_o), 32'd0);
        if (t.v && t.op == 3'd2 && t.a % 4 == 0) ram_m[(t.a / 4) % DEPTH] = t.d;
        @(posedge clk_i); #1;
        chk({n, " valid"}, 32'(valid_o), 32'(t.e_valid));
        chk({n, " we"}, 32'(reg_write_o), 32'(t.e_we));
        chk({n, " err"}, 32'(err_o), 32'(t.e_err));
        if (t.e_valid) chk({n, " data"}, wb_data_o, t.e_data);
        if (t.e_valid && t.op != 3'd2) chk({n, " rsd"}, 32'(rsd_o), 32'(t.r));
    endtask

    initial begin
        tbl[0]  = '{1'b1, 3'd0, 32'h1234, 32'h0, 5'd5, 0, 1'b1, 32'h1234, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 3'd0, 32'h1234, 32'h0, 5'd0, 0, 1'b1, 32'h1234, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 5'd0, 0, 1'b1, 32'h0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 3'd1, 32'h10, 32'h0, 5'd7, S, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 3'd2, 32'h400, 32'hA5A5A5A5, 5'd0, 0, 1'b1, 32'h0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 3'd1, 32'h0, 32'h0, 5'd3, S, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 3'd2, 32'h13, 32'h11111111, 5'd0, 0, 1'b1, 32'h0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 3'd1, 32'h10, 32'h0, 5'd4, S, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 3'd1, 32'h22, 32'h0, 5'd9, 0, 1'b1, 32'h0, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 3'd3, 32'h55, 32'h0, 5'd6, 0, 1'b1, 32'h0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 3'd7, 32'h66, 32'h0, 5'd2, 0, 1'b1, 32'h0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 3'd0, 32'h99, 32'h0, 5'd5, 0, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 3'd1, 32'h10, 32'h0, 5'd8, S, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 3'd1, 32'h0, 32'h0, 5'd1, S, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 3'd2, 32'h0, 32'h12345678, 5'd0, 0, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 3'd1, 32'h400, 32'h0, 5'd0, S, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0};

        valid_i = 1'b1; Op_i = 3'd1; alu_result_i = 32'h10; rsd_i = 5'd7;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset stall", 32'(stall_o), 32'd0);
        chk("reset valid", 32'(valid_o), 32'd0);
        chk("reset data", wb_data_o, 32'd0);
        chk("reset rsd", 32'(rsd_o), 32'd0);
        chk("reset we", 32'(reg_write_o), 32'd0);
        chk("reset err", 32'(err_o), 32'd0);
        rst_i = 1'b1;

        for (int i = 0; i < 16; i++) apply(tbl[i], $sformatf("tbl%0d", i));

        valid_i = 1'b1; Op_i = 3'd1; alu_result_i = 32'h10; rsd_i = 5'd7;
        #1 chk("midrst stall", 32'(stall_o), 32'd1);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        #1 chk("midrst stall forced", 32'(stall_o), 32'd0);
        @(posedge clk_i); #1;
        chk("midrst valid", 32'(valid_o), 32'd0);
        chk("midrst data", wb_data_o, 32'd0);
        chk("midrst rsd", 32'(rsd_o), 32'd0);
        chk("midrst we", 32'(reg_write_o), 32'd0);
        chk("midrst err", 32'(err_o), 32'd0);
        rst_i = 1'b1;
        apply('{1'b1, 3'd0, 32'h77, 32'h0, 5'd3, 0, 1'b1, 32'h77, 1'b1, 1'b0}, "post-reset alu");

        valid_i = 1'b1; Op_i = 3'd1; alu_result_i = 32'h10; rsd_i = 5'd7;
        #1 chk("drop stall", 32'(stall_o), 32'd1);
        @(posedge clk_i); #1;
        chk("drop bubble", 32'(valid_o), 32'd0);
        valid_i = 1'b0;
        #1 chk("drop stall off", 32'(stall_o), 32'd0);
        @(posedge clk_i); #1;
        chk("drop valid", 32'(valid_o), 32'd0);
        chk("drop we", 32'(reg_write_o), 32'd0);
        apply('{1'b1, 3'd0, 32'h88, 32'h0, 5'd4, 0, 1'b1, 32'h88, 1'b1, 1'b0}, "post-drop alu");

        for (int w = 0; w < DEPTH; w++)
            apply(model(1'b1, 3'd2, 32'(w * 4), $urandom, 5'd0), "fill");

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            logic [2:0]  op;
            int          c = $urandom_range(0, 9);
            op = c < 3 ? 3'd0 : c < 6 ? 3'd1 : c < 8 ? 3'd2 : c == 8 ? 3'd3 : 3'(4 + $urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            apply(model($urandom_range(0, 9) != 0, op, a, $urandom, 5'($urandom_range(0, 31))), "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
